// File: rtl/period_spi_loader_pkg.sv
// Shared constants and state encoding for the serial period loader.
// BITS / DEFAULT_PERIOD are shared with the frequency counter so both agree.
package period_spi_loader_pkg;

    localparam int PKG_BITS           = 12;
    localparam int PKG_DEFAULT_PERIOD = 1200;
    localparam int PKG_MIN_PERIOD     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, followed by a history flop
// so that rising/falling edges of the synchronised value can be detected.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Synchroniser chain plus one-cycle history of the synchronised value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_hist <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_hist;
    assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/period_spi_loader.sv
// Receives a measurement period over a 3-wire serial link (MSB first),
// range-checks it and presents it to the counter with a one-cycle load strobe.
// Malformed frames set a sticky error flag and are discarded.
module period_spi_loader
    import period_spi_loader_pkg::*;
#(
    parameter int BITS           = PKG_BITS,
    parameter int DEFAULT_PERIOD = PKG_DEFAULT_PERIOD,
    parameter int MIN_PERIOD     = PKG_MIN_PERIOD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sclk,
    input  logic            mosi,
    input  logic            cs_n,
    output logic [BITS-1:0] period,
    output logic            period_load,
    output logic            busy,
    output logic            frame_error
);

    localparam int              CW       = $clog2(BITS + 2);
    localparam logic [CW-1:0]   CNT_FULL = CW'(BITS);
    localparam logic [CW-1:0]   CNT_SAT  = CW'(BITS + 1);
    localparam logic [BITS-1:0] MIN_W    = BITS'(MIN_PERIOD);
    localparam logic [BITS-1:0] DEF_W    = BITS'(DEFAULT_PERIOD);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_cs_sync,   w_cs_rise,   w_cs_fall;
    logic w_unused;

    // mosi uses the same pipeline depth as sclk, so its synced value is
    // valid in the cycle the synced sclk rise is seen.
    sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .i_async(sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .i_async(mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    // cs_n history resets low, so a frame already open at reset release
    // never produces a fall and is ignored.
    sync_edge #(.RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk), .reset(reset), .i_async(cs_n),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    assign w_unused = ^{w_sclk_sync, w_sclk_fall, w_mosi_rise, w_mosi_fall, w_cs_sync};

    state_t          r_state, w_next_state;
    logic [BITS-1:0] r_shift;
    logic [CW-1:0]   r_bit_cnt;
    logic [BITS-1:0] r_period;
    logic            r_load;
    logic            r_error;

    logic w_busy, w_start, w_shift_en, w_check, w_accept;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic; a bit arriving with cs_n rise is still shifted
    // because the datapath acts on the same edge that leaves SHIFT.
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = w_cs_fall ? SHIFT : IDLE;
            SHIFT:   w_next_state = w_cs_rise ? CHECK : SHIFT;
            CHECK:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output / control decode from the current state
    always_comb begin
        w_busy     = 1'b0;
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_check    = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            IDLE:  w_start = w_cs_fall;
            SHIFT: begin
                w_busy     = 1'b1;
                w_shift_en = w_sclk_rise;
            end
            CHECK: begin
                w_busy   = 1'b1;
                w_check  = 1'b1;
                w_accept = (r_bit_cnt == CNT_FULL) && (r_shift >= MIN_W);
            end
            default: ;
        endcase
    end

    // Deserialiser, bit counter, accepted period, strobe and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_period  <= DEF_W;
            r_load    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (w_start) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_error   <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift <= {r_shift[BITS-2:0], w_mosi_sync};
                if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            if (w_check) begin
                if (w_accept) begin
                    r_period <= r_shift;
                    r_load   <= 1'b1;
                end else begin
                    r_error  <= 1'b1;
                end
            end
        end
    end

    assign period      = r_period;
    assign period_load = r_load;
    assign busy        = w_busy;
    assign frame_error = r_error;

endmodule

// File: tb/tb_period_spi_loader.sv
// Self-checking bench for period_spi_loader: frames are driven at sclk=clk/8,
// expected loaded periods are queued at drive time and compared on each strobe.
module tb_period_spi_loader;

    localparam int BITS = 12;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            sclk  = 1'b0;
    logic            mosi  = 1'b0;
    logic            cs_n  = 1'b1;
    logic [BITS-1:0] period;
    logic            period_load;
    logic            busy;
    logic            frame_error;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    logic [BITS-1:0] exp_q[$];
    logic [BITS-1:0] model_period = 12'd1200;

    period_spi_loader #(
        .BITS(12),
        .DEFAULT_PERIOD(1200),
        .MIN_PERIOD(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sclk(sclk),
        .mosi(mosi),
        .cs_n(cs_n),
        .period(period),
        .period_load(period_load),
        .busy(busy),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && period_load === 1'b1) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got period=%0d with nothing expected", period);
            end else begin
                logic [BITS-1:0] e;
                e = exp_q.pop_front();
                if (period !== e) begin
                    errors++;
                    $display("FAIL strobe_period got %0d expected %0d", period, e);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame of nbits (MSB first). align_last raises cs_n together
    // with the final sclk rise. Returns strobe latency in cycles after cs_n
    // rise (0 = none) and busy one cycle after the strobe.
    task automatic send_frame(input logic [15:0] val, input int nbits, input bit align_last,
                              output int lat, output logic busy_after);
        if (nbits == BITS && val[11:0] >= 12'd16) begin
            exp_q.push_back(val[11:0]);
            model_period = val[11:0];
        end
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = val[i];
            wait_clk(4);
            sclk = 1'b1;
            if (i == 0 && align_last) begin
                cs_n = 1'b1;
            end else begin
                wait_clk(4);
                sclk = 1'b0;
            end
        end
        if (!(align_last && nbits > 0)) begin
            wait_clk(4);
            cs_n = 1'b1;
        end
        lat        = 0;
        busy_after = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (lat != 0 && k == lat + 1) busy_after = busy;
            if (period_load === 1'b1 && lat == 0) lat = k;
        end
        @(posedge clk);
        #1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_reset;
        int s;
        reset = 1'b1;
        wait_clk(1);
        checks++; if (period !== 12'd1200) begin errors++; $display("FAIL reset_period got %0d expected 1200", period); end
        checks++; if (period_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b expected 0", period_load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b expected 0", frame_error); end
        wait_clk(1);
        reset = 1'b0;
        s = strobes;
        wait_clk(8);
        checks++; if (strobes !== s) begin errors++; $display("FAIL reset_no_strobe got %0d strobes expected 0", strobes - s); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b expected 0", busy); end
    endtask

    task automatic test_valid_600;
        int lat; logic ba; int s;
        s = strobes;
        send_frame(16'h0258, 12, 1'b0, lat, ba);
        checks++; if (strobes - s !== 1) begin errors++; $display("FAIL valid_strobe_count got %0d expected 1", strobes - s); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL valid_latency got %0d expected 4", lat); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL valid_busy_after got %b expected 0", ba); end
        checks++; if (period !== 12'd600) begin errors++; $display("FAIL valid_period got %0d expected 600", period); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL valid_error got %b expected 0", frame_error); end
    endtask

    task automatic test_length;
        int lat; logic ba; int s;
        logic [15:0] v [3];
        int          n [3];
        v = '{16'h07FF, 16'h1ABC, 16'h0000};
        n = '{11, 13, 0};
        for (int t = 0; t < 3; t++) begin
            s = strobes;
            send_frame(v[t], n[t], 1'b0, lat, ba);
            checks++; if (strobes !== s) begin errors++; $display("FAIL len%0d_strobe got %0d expected 0", n[t], strobes - s); end
            checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL len%0d_error got %b expected 1", n[t], frame_error); end
            checks++; if (period !== model_period) begin errors++; $display("FAIL len%0d_period got %0d expected %0d", n[t], period, model_period); end
        end
        send_frame(16'h00C8, 12, 1'b0, lat, ba);
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL recover_error got %b expected 0", frame_error); end
        checks++; if (period !== 12'd200) begin errors++; $display("FAIL recover_period got %0d expected 200", period); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL recover_latency got %0d expected 4", lat); end
    endtask

    task automatic test_range;
        int lat; logic ba; int s;
        s = strobes;
        send_frame(16'h0005, 12, 1'b0, lat, ba);
        checks++; if (strobes !== s) begin errors++; $display("FAIL small_strobe got %0d expected 0", strobes - s); end
        checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL small_error got %b expected 1", frame_error); end
        checks++; if (period !== 12'd200) begin errors++; $display("FAIL small_period got %0d expected 200", period); end
        send_frame(16'h0010, 12, 1'b0, lat, ba);
        checks++; if (lat !== 4) begin errors++; $display("FAIL min_latency got %0d expected 4", lat); end
        checks++; if (period !== 12'd16) begin errors++; $display("FAIL min_period got %0d expected 16", period); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL min_error got %b expected 0", frame_error); end
    endtask

    task automatic test_aligned_last;
        int lat; logic ba;
        send_frame(16'h0FFF, 12, 1'b1, lat, ba);
        checks++; if (lat !== 4) begin errors++; $display("FAIL aligned_latency got %0d expected 4", lat); end
        checks++; if (period !== 12'd4095) begin errors++; $display("FAIL aligned_period got %0d expected 4095", period); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL aligned_error got %b expected 0", frame_error); end
    endtask

    task automatic test_reset_mid_frame;
        int lat; logic ba; int s;
        logic [11:0] v;
        v = 12'h3E8;
        s = strobes;
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 11; i >= 0; i--) begin
            mosi = v[i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            if (i == 6) begin
                reset = 1'b1;
                wait_clk(2);
                reset = 1'b0;
                model_period = 12'd1200;
            end
        end
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(12);
        mosi = 1'b0;
        checks++; if (strobes !== s) begin errors++; $display("FAIL midreset_strobe got %0d expected 0", strobes - s); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL midreset_error got %b expected 0", frame_error); end
        checks++; if (period !== 12'd1200) begin errors++; $display("FAIL midreset_period got %0d expected 1200", period); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b expected 0", busy); end
        send_frame(16'h03E8, 12, 1'b0, lat, ba);
        checks++; if (lat !== 4) begin errors++; $display("FAIL after_reset_latency got %0d expected 4", lat); end
        checks++; if (period !== 12'd1000) begin errors++; $display("FAIL after_reset_period got %0d expected 1000", period); end
    endtask

    initial begin
        test_reset();
        test_valid_600();
        test_length();
        test_range();
        test_aligned_last();
        test_reset_mid_frame();
        wait_clk(8);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pending_strobes got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
